mbist_march_ctrl: RTL and testbench
===================================

# mbist_march_ctrl

March C- built-in self-test controller that sits directly upstream of the synchronous `memory` block and drives its `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` port. It reads back `mem_rdata` and flags mismatches. Detected faulty addresses stream out on a pulse interface to the downstream repair (MBISR) logic. One memory operation is issued per clock, with an aggregate pass/fail result at the end.

## Interface
- `ADDR_WIDTH`, 8, memory address width
- `DATA_WIDTH`, 8, memory data width
- `MEM_SIZE`, 256, number of words tested (addresses 0..MEM_SIZE-1); must be ≥2 and ≤2^ADDR_WIDTH
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin test; sampled only in IDLE or DONE
- `mem_en`  out  1  memory enable; high on every test cycle
- `mem_we`  out  1  high on write ops, low on read ops
- `mem_addr`  out  ADDR_WIDTH  current test address
- `mem_wdata`  out  DATA_WIDTH  write background: all-0 or all-1
- `mem_rdata`  in  DATA_WIDTH  combinational read data from memory, same cycle
- `busy`  out  1  test in progress
- `done`  out  1  test finished; held until `start` or `rst`
- `fail`  out  1  sticky: at least one mismatch this run
- `fail_valid`  out  1  one-cycle pulse per mismatch
- `fail_addr`  out  ADDR_WIDTH  address of the mismatch reported by `fail_valid`
- `fail_count`  out  8  mismatch count, saturates at 255

## Operation
- States: IDLE → RUN → DONE. IDLE/DONE + `start` → RUN. RUN + last op of M5 → DONE. Any state + `rst` → IDLE.
- March C- elements, with index `elem` 0..5 and op index `op` 0..1:
  - M0: ↑(w0), 1 op per address
  - M1: ↑(r0,w1)
  - M2: ↑(r1,w0)
  - M3: ↓(r0,w1)
  - M4: ↓(r1,w0)
  - M5: ↑(r0), 1 op per address
- ↑ runs 0→MEM_SIZE-1 and ↓ runs MEM_SIZE-1→0. The address counter never leaves this range; non-power-of-2 `MEM_SIZE` is legal.
- Element advance: after the last op at the last address of the element, the address is reloaded to 0 (↑) or MEM_SIZE-1 (↓) and `op` returns to 0.
- Memory port outputs are decoded from registered state, so they are glitch-free at the clock edge. In IDLE/DONE: `mem_en`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Read compare is done in the same cycle: `mem_rdata` is compared against the expected background (r0→all-0, r1→all-1), and any bit difference is a mismatch.
- Each mismatch, registered at the clock edge, produces:
  - `fail_valid`=1 for exactly one cycle
  - `fail_addr` set to the read address
  - `fail` set
  - `fail_count` incremented, saturating at 255
- `start` in RUN is ignored.
- `start` from DONE clears `done`, `fail`, and `fail_count`, then reruns the test.
- Reset values: all outputs 0; state IDLE.

## Timing
- Total RUN length is exactly 10·MEM_SIZE cycles (M0 and M5 use N cycles each; M1–M4 use 2N each). For MEM_SIZE=256 this is 2560 cycles.
- `start` high at edge k: `busy`=1 and the first op (w0 at address 0) are presented during cycle k+1.
- The last op (M5 r0 at address 0 or MEM_SIZE-1 per the ↑ rule, i.e. MEM_SIZE-1) occupies the final RUN cycle. At the next edge: `busy`=0 and `done`=1.
- A mismatch in cycle c produces `fail_valid`/`fail_addr` during cycle c+1. For a final-cycle mismatch, this means the pulse coincides with the first `done` cycle.
- A reset mid-run reaches IDLE at the next edge with all outputs 0. No pending `fail_valid` pulse is emitted. The memory is cleared by the same `rst`.

## Configuration
- `MBIST_STOP_ON_FAIL_EN` defined:
  - The first mismatch ends the run: the next state is DONE, with `fail`=1, `fail_count`=1, and `fail_valid` pulsed once.
  - `fail_addr` holds the failing address until the next `start`/`rst`.
- Not defined:
  - The run always completes all six elements.
  - Every mismatch is reported and counted.
  - `fail_addr` holds the last reported address.

## Test plan
- Fault-free memory, MEM_SIZE=256, `start` pulse → `busy` high for 2560 cycles, then `done`=1, `fail`=0, `fail_count`=0, no `fail_valid`.
- Bench forces `mem_rdata` bit 0 stuck-at-1 at address 0x12 (macro off) → mismatches in M1 r0, M3 r0, and M5 r0. Result: three `fail_valid` pulses with `fail_addr`=0x12, then `fail_count`=3 and `fail`=1 at `done`.
- Same fault, `MBIST_STOP_ON_FAIL_EN` defined → DONE reached at cycle 256+2·0x12+1 after start, with `fail_count`=1 and `fail_addr`=0x12.
- `rst` asserted 1000 cycles into RUN → next cycle: IDLE, `busy`=`mem_en`=`done`=`fail`=0, `fail_count`=0.
- `start` re-asserted while busy → ignored: `done` still arrives exactly 2560 cycles after the original start.
- From DONE with `fail`=1, fault removed, `start` → `fail`/`fail_count` cleared, and a clean 2560-cycle rerun ends `done`=1, `fail`=0.

Source files
------------

// File: rtl/mbist_march_ctrl_if.sv
// Memory-side port of the March C- BIST controller: enable, write strobe, address,
// write data and the combinational read data returned by the memory.
interface mbist_march_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: one memory op per clock, same-cycle read compare, fault stream.
// Optional macro MBIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module mbist_march_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mbist_march_ctrl_if.master    mem,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic                  fail_valid,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            fail_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_SIZE - 1);

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  fail_q, fail_d;
  logic                  fail_valid_q, fail_valid_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [7:0]            fail_count_q, fail_count_d;

  logic                  run;
  logic                  is_read;
  logic                  bg;
  logic                  down;
  logic                  last_op;
  logic                  last_addr;
  logic                  mismatch;

  // Decode the current op from registered element/op indices.
  always_comb begin
    run       = (state_q == StRun);
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    last_op   = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
    last_addr = down ? (addr_q == '0) : (addr_q == LastAddr);
    is_read   = (elem_q == 3'd5) || ((elem_q != 3'd0) && !op_q);
    // Background bit: write value for write ops, expected value for read ops.
    bg        = ((elem_q == 3'd1) &&  op_q) || ((elem_q == 3'd2) && !op_q) ||
                ((elem_q == 3'd3) &&  op_q) || ((elem_q == 3'd4) && !op_q);
    mismatch  = run && is_read && (mem.mem_rdata != {DATA_WIDTH{bg}});
  end

  always_comb begin
    mem.mem_en    = run;
    mem.mem_we    = run && !is_read;
    mem.mem_addr  = run ? addr_q : '0;
    mem.mem_wdata = run ? {DATA_WIDTH{bg}} : '0;
    busy          = run;
    done          = (state_q == StDone);
    fail          = fail_q;
    fail_valid    = fail_valid_q;
    fail_addr     = fail_addr_q;
    fail_count    = fail_count_q;
  end

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    op_d         = op_q;
    addr_d       = addr_q;
    fail_d       = fail_q;
    fail_valid_d = 1'b0;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StRun;
          elem_d       = 3'd0;
          op_d         = 1'b0;
          addr_d       = '0;
          fail_d       = 1'b0;
          fail_addr_d  = '0;
          fail_count_d = 8'd0;
        end
      end
      StRun: begin
        if (last_op) begin
          op_d = 1'b0;
          if (last_addr) begin
            if (elem_q == 3'd5) begin
              state_d = StDone;
            end else begin
              elem_d = elem_q + 3'd1;
              // Elements M3 and M4 walk downwards.
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LastAddr : '0;
            end
          end else begin
            addr_d = down ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
          end
        end else begin
          op_d = 1'b1;
        end
        if (mismatch) begin
          fail_valid_d = 1'b1;
          fail_addr_d  = addr_q;
          fail_d       = 1'b1;
          if (fail_count_q != 8'hff) fail_count_d = fail_count_q + 8'd1;
`ifdef MBIST_STOP_ON_FAIL_EN
          state_d = StDone;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      elem_q       <= 3'd0;
      op_q         <= 1'b0;
      addr_q       <= '0;
      fail_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      fail_q       <= fail_d;
      fail_valid_q <= fail_valid_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a behavioural memory and an optional
// stuck-at-1 fault on bit 0 of address 0x12.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, fail, fail_valid;
  logic [7:0] fail_addr, fail_count;
  logic       fault_on;
  logic [7:0] mem_q [256];

  int tests_run    = 0;
  int tests_failed = 0;

  mbist_march_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  mbist_march_ctrl #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .MEM_SIZE  (256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem       (bus),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_valid(fail_valid),
    .fail_addr (fail_addr),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
    end else if (bus.mem_en && bus.mem_we) begin
      mem_q[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem_q[bus.mem_addr] |
                         ((fault_on && bus.mem_addr == 8'h12) ? 8'h01 : 8'h00);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and follows it to done (bounded); cycles counts edges after the start edge.
  task automatic run_test(input int restart_at, output int cycles, output int pulses,
                          output int first_pulse, output int bad_addr, output int busy_drops);
    pulses = 0; first_pulse = -1; bad_addr = 0; busy_drops = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_fail_clr", fail, 0);
    check("start_cnt_clr", fail_count, 0);
    check("first_op", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {2'b11, 16'h0000});
    while (!done && cycles < 3000) begin
      if (cycles == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
      cycles++;
      if (fail_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = cycles;
        if (fail_addr != 8'h12) bad_addr++;
      end
      if (!done && !busy) busy_drops++;
      if (cycles == 256) check("m1_r0_a0", {bus.mem_we, bus.mem_addr}, {1'b0, 8'h00});
      if (cycles == 257) check("m1_w1_a0", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                               {1'b1, 8'h00, 8'hff});
      if (cycles == 1280) check("m3_r0_top", {bus.mem_we, bus.mem_addr}, {1'b0, 8'hff});
      if (cycles == 2559) check("m5_last", {bus.mem_we, bus.mem_addr}, {1'b0, 8'hff});
    end
  endtask

  int cyc, np, fp, ba, bd;

  initial begin
    rst = 1'b1; start = 1'b0; fault_on = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_cnt", fail_count, 0);
    check("rst_fv", fail_valid, 0);
    check("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);

    // Clean run.
    run_test(-1, cyc, np, fp, ba, bd);
    check("clean_len", cyc, 2560);
    check("clean_pulses", np, 0);
    check("clean_busy", bd, 0);
    check("clean_done", done, 1);
    check("clean_fail", fail, 0);
    check("clean_cnt", fail_count, 0);
    check("clean_idle_mem", {bus.mem_en, bus.mem_addr}, 0);
    tick(); tick(); tick();
    check("done_held", done, 1);

    // Stuck-at-1 on bit 0 of address 0x12.
    fault_on = 1'b1;
    run_test(-1, cyc, np, fp, ba, bd);
`ifdef MBIST_STOP_ON_FAIL_EN
    check("stop_len", cyc, 256 + 2 * 18 + 1);
    check("stop_pulses", np, 1);
    check("stop_cnt", fail_count, 1);
`else
    check("fault_len", cyc, 2560);
    check("fault_pulses", np, 3);
    check("fault_cnt", fail_count, 3);
`endif
    check("fault_first", fp, 293);
    check("fault_addr_bad", ba, 0);
    check("fault_fail", fail, 1);
    check("fault_done", done, 1);
    tick(); tick();
    check("fault_addr_hold", fail_addr, 8'h12);
    check("fault_fv_low", fail_valid, 0);

    // Rerun from DONE with the fault removed clears the sticky results.
    fault_on = 1'b0;
    run_test(-1, cyc, np, fp, ba, bd);
    check("rerun_len", cyc, 2560);
    check("rerun_pulses", np, 0);
    check("rerun_fail", fail, 0);
    check("rerun_cnt", fail_count, 0);

    // Start re-asserted mid-run is ignored.
    run_test(100, cyc, np, fp, ba, bd);
    check("restart_len", cyc, 2560);
    check("restart_busy", bd, 0);

    // Reset 1000 cycles into a faulty run.
    fault_on = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    check("prerst_fail", fail, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fault_on = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_en", bus.mem_en, 0);
    check("midrst_done", done, 0);
    check("midrst_fail", fail, 0);
    check("midrst_cnt", fail_count, 0);
    check("midrst_fv", fail_valid, 0);
    tick();
    check("midrst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
